qam16_frame_ctrl: RTL and testbench
===================================

Name: qam16_frame_ctrl

Overview:
- Frame scheduler for the 16QAM modulator.
- Owns the symbol-rate timebase and sequences each frame as a fixed preamble, then PAYLOAD_LEN data symbols pulled from an upstream valid/ready source, then a silent guard interval.
- Presents one registered 4-bit symbol code (plus split I/Q) per symbol period to the I/Q multiplier stage, and gates modulation via mod_en.

Parameters:
- SYM_DIV, 4: clocks per symbol period; must be >= 2.
- PREAMBLE_LEN, 8: preamble symbols per frame; must be >= 1.
- PAYLOAD_LEN, 64: payload symbols per frame; must be >= 1.
- GUARD_LEN, 4: silent symbol periods after the payload; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- s_data  in  4  payload symbol code.
- s_valid  in  1  s_data valid.
- s_ready  out  1  payload symbol is consumed this cycle (combinational).
- sym_code  out  4  current symbol code (registered).
- sym_i  out  2  signed I level = {sym_code[3], sym_code[1]}.
- sym_q  out  2  signed Q level = {sym_code[2], sym_code[0]}.
- sym_stb  out  1  one-cycle pulse when a new sym_code is presented.
- mod_en  out  1  high while a preamble or payload symbol is presented.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when the frame completes.
- underrun  out  1  sticky flag: a payload tick found s_valid low.

Behaviour:
- Reset: state=IDLE, sym_cnt=0, idx=0, all outputs 0, underrun cleared.
- States: IDLE, PREAMBLE, PAYLOAD, GUARD.
- Timebase: sym_cnt is cleared on start acceptance, then counts 0..SYM_DIV-1 and wraps. tick = (state != IDLE) && (sym_cnt == 0).
- IDLE: start=1 sets sym_cnt=0, idx=0 and moves to PREAMBLE. start is ignored while busy; it is level-sampled, not queued.
- Latency: start sampled at edge E0, tick in the cycle after E0, sym_stb=1 in the cycle after E1 (2 clocks). Subsequent sym_stb pulses are exactly SYM_DIV clocks apart.
- Output update: all registered outputs update only on the edge ending a tick cycle. sym_stb=1 for the following cycle only.
- PREAMBLE: symbols alternate 4'hA, 4'h5, starting with 4'hA at idx=0. mod_en=1. On the tick with idx==PREAMBLE_LEN-1, move to PAYLOAD and set idx=0.
- PAYLOAD, handshake: s_ready = (state==PAYLOAD) && tick, and is never high at any other time. s_data is sampled on that edge when s_valid=1.
- PAYLOAD, underrun: if s_valid=0 at the tick, emit 4'h0, set underrun, and still count the symbol. Frame length is fixed.
- PAYLOAD, exit: mod_en=1. On the tick with idx==PAYLOAD_LEN-1, move to GUARD and set idx=0.
- GUARD: on each tick, sym_code=0, mod_en=0, sym_stb=1. On the tick with idx==GUARD_LEN-1, move to IDLE with frame_done=1 for one cycle (aligned with that sym_stb).
- Back-to-back frames: start is accepted in the first IDLE cycle, giving no extra gap.
- underrun clears only on reset or on start acceptance.
- A reset mid-frame aborts immediately to reset values with no frame_done. s_ready is 0 during reset.
- Width rule: idx is sized by $clog2 of the maximum length parameter, with wrap compares on exact equality.

Optional Feature:
- QAM16_SCRAMBLE_EN defined: payload codes are XORed with a whitening mask.
  - 7-bit LFSR s, seeded 7'h7F on start acceptance.
  - Step: new = s[6]^s[5]; s = {s[5:0], new}.
  - Four steps per payload tick. The first new bit maps to mask[3], the last to mask[0].
  - Underrun symbols are also masked; preamble and guard are not.
- Undefined: no LFSR logic; payload passes unmodified.

Decomposition:
- Shared package qam16_pkg holds:
  - state encodings
  - preamble constants 4'hA and 4'h5
  - the I/Q bit-split convention {code[3],code[1]} / {code[2],code[0]}
  - the LFSR seed 7'h7F
- One natural sub-module, qam16_scrambler: the LFSR with load and step-by-4 enable, instantiated only under QAM16_SCRAMBLE_EN.

Test Plan:
- Defaults, start pulse, s_valid held 1 with s_data=4'h3:
  - first sym_stb 2 clocks after start; strobes every 4 clocks
  - 8 preamble codes A,5,A,5…; 64 codes 3 (sym_i=2'b01, sym_q=2'b01)
  - 4 guard zeros with mod_en=0; frame_done on the 76th strobe
- s_valid=0 on payload ticks 5–6 -> s_ready still pulses, codes 0 emitted, underrun=1, frame still ends on the 76th strobe; next start clears underrun.
- start held high across two frames -> second frame's first strobe exactly 2 clocks after frame_done; start pulses while busy are ignored.
- reset asserted mid-payload -> next cycle all outputs 0, state IDLE, no frame_done; a new start runs a full, correct frame.
- s_ready check -> never high outside PAYLOAD tick cycles; an s_valid toggling off-tick is never consumed.
- QAM16_SCRAMBLE_EN with payload all 4'h0 -> first two payload codes 4'h0, 4'h2; preamble unchanged.

Source files
------------

// File: rtl/qam16_pkg.sv
// qam16_pkg
//   Shared definitions for the 16QAM frame scheduler slice.
//   - state_t        : frame sequencer states
//   - PREAMBLE_EVEN  : preamble code presented on even preamble indices
//   - PREAMBLE_ODD   : preamble code presented on odd preamble indices
//   - LFSR_SEED      : whitening LFSR seed (used only when QAM16_SCRAMBLE_EN is defined)
//   - code_to_i/q    : split a 4-bit symbol code into its signed I and Q levels
//   - lfsr_step      : one step of the 7-bit whitening LFSR
package qam16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_GUARD
  } state_t;

  localparam logic [3:0] PREAMBLE_EVEN = 4'hA;
  localparam logic [3:0] PREAMBLE_ODD  = 4'h5;
  localparam logic [6:0] LFSR_SEED     = 7'h7F;

  // The odd code bits carry I and the even code bits carry Q, MSB first,
  // so each 2-bit level is a signed value for the I/Q multiplier stage.
  function automatic logic [1:0] code_to_i(input logic [3:0] code);
    return {code[3], code[1]};
  endfunction

  function automatic logic [1:0] code_to_q(input logic [3:0] code);
    return {code[2], code[0]};
  endfunction

  // New bit is shifted in at the LSB, so after a step the fresh bit is s[0].
  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage

// File: rtl/qam16_scrambler.sv
// qam16_scrambler
//   7-bit whitening LFSR that advances four steps per payload symbol and
//   exposes the four new bits as a code mask. Only instantiated by
//   qam16_frame_ctrl when QAM16_SCRAMBLE_EN is defined.
// Ports:
//   clk   in   system clock
//   reset in   synchronous active-high reset (reloads the seed)
//   load  in   reload the seed (frame start)
//   step  in   advance four steps (payload symbol consumed)
//   mask  out  whitening mask for the current payload symbol; the first
//              new bit lands in mask[3], the last in mask[0]
module qam16_scrambler
  import qam16_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  output logic [3:0] mask
);

  logic [6:0] lfsr;
  logic [6:0] s1, s2, s3, s4;

  // Unroll the four steps combinationally so the mask for this symbol is
  // available in the same cycle the symbol is registered.
  assign s1   = lfsr_step(lfsr);
  assign s2   = lfsr_step(s1);
  assign s3   = lfsr_step(s2);
  assign s4   = lfsr_step(s3);
  assign mask = {s1[0], s2[0], s3[0], s4[0]};

  // Seed register: reloaded at every frame start, advanced once per payload tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= s4;
    end
  end

endmodule

// File: rtl/qam16_frame_ctrl.sv
// qam16_frame_ctrl
//   Frame scheduler for the 16QAM modulator. Owns the symbol-rate timebase
//   and sequences each frame as PREAMBLE_LEN alternating A/5 symbols,
//   PAYLOAD_LEN symbols pulled from a valid/ready source, then GUARD_LEN
//   silent symbol periods.
//   Optional macro QAM16_SCRAMBLE_EN: payload codes (including underrun
//   zeros) are XORed with a whitening mask from qam16_scrambler.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   frame request, sampled only in IDLE
//   s_data     in   payload symbol code
//   s_valid    in   s_data valid
//   s_ready    out  payload symbol consumed this cycle (combinational)
//   sym_code   out  current symbol code (registered)
//   sym_i      out  signed I level {sym_code[3], sym_code[1]}
//   sym_q      out  signed Q level {sym_code[2], sym_code[0]}
//   sym_stb    out  one-cycle pulse when a new sym_code is presented
//   mod_en     out  high while a preamble or payload symbol is presented
//   busy       out  frame in progress
//   frame_done out  one-cycle pulse with the final guard strobe
//   underrun   out  sticky: a payload tick found s_valid low
module qam16_frame_ctrl
  import qam16_pkg::*;
#(
  parameter int unsigned SYM_DIV      = 4,
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned PAYLOAD_LEN  = 64,
  parameter int unsigned GUARD_LEN    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [3:0] sym_code,
  output logic [1:0] sym_i,
  output logic [1:0] sym_q,
  output logic       sym_stb,
  output logic       mod_en,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned MAX_LEN =
    (PREAMBLE_LEN >= PAYLOAD_LEN && PREAMBLE_LEN >= GUARD_LEN) ? PREAMBLE_LEN :
    (PAYLOAD_LEN >= GUARD_LEN) ? PAYLOAD_LEN : GUARD_LEN;
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_W = $clog2(SYM_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_DIV - 1);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [IDX_W-1:0] GRD_LAST = IDX_W'(GUARD_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] sym_cnt;
  logic [IDX_W-1:0] idx;
  logic             tick;
  logic             start_accept;
  logic [3:0]       raw_code;
  logic [3:0]       payload_code;

  // A tick is the first clock of each symbol period while a frame runs.
  assign tick         = (state != ST_IDLE) && (sym_cnt == '0);
  assign start_accept = (state == ST_IDLE) && start;
  // Gated by reset so an aborted frame can never consume a symbol.
  assign s_ready      = !reset && (state == ST_PAYLOAD) && tick;
  assign busy         = (state != ST_IDLE);
  assign sym_i        = code_to_i(sym_code);
  assign sym_q        = code_to_q(sym_code);
  // An empty source still produces a symbol so the frame length stays fixed.
  assign raw_code     = s_valid ? s_data : 4'h0;

`ifdef QAM16_SCRAMBLE_EN
  logic [3:0] mask;

  qam16_scrambler u_scrambler (
    .clk   (clk),
    .reset (reset),
    .load  (start_accept),
    .step  (s_ready),
    .mask  (mask)
  );

  assign payload_code = raw_code ^ mask;
`else
  assign payload_code = raw_code;
`endif

  // Frame sequencer: timebase, symbol index and every registered output.
  // Outputs only change on the edge closing a tick cycle; sym_stb and
  // frame_done default low so they last exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sym_cnt    <= '0;
      idx        <= '0;
      sym_code   <= 4'h0;
      sym_stb    <= 1'b0;
      mod_en     <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sym_stb    <= 1'b0;
      frame_done <= 1'b0;

      if (state != ST_IDLE) begin
        sym_cnt <= (sym_cnt == CNT_LAST) ? '0 : sym_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (start_accept) begin
            state    <= ST_PREAMBLE;
            sym_cnt  <= '0;
            idx      <= '0;
            underrun <= 1'b0;
          end
        end

        ST_PREAMBLE: begin
          if (tick) begin
            sym_code <= idx[0] ? PREAMBLE_ODD : PREAMBLE_EVEN;
            sym_stb  <= 1'b1;
            mod_en   <= 1'b1;
            if (idx == PRE_LAST) begin
              state <= ST_PAYLOAD;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        ST_PAYLOAD: begin
          if (tick) begin
            sym_code <= payload_code;
            sym_stb  <= 1'b1;
            mod_en   <= 1'b1;
            if (!s_valid) begin
              underrun <= 1'b1;
            end
            if (idx == PAY_LAST) begin
              state <= ST_GUARD;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        ST_GUARD: begin
          if (tick) begin
            sym_code <= 4'h0;
            sym_stb  <= 1'b1;
            mod_en   <= 1'b0;
            if (idx == GRD_LAST) begin
              state      <= ST_IDLE;
              idx        <= '0;
              frame_done <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qam16_frame_ctrl.sv
// tb_qam16_frame_ctrl
//   Directed bench for qam16_frame_ctrl at default parameters. A negedge
//   monitor logs every strobe, s_ready pulse and frame_done pulse; each
//   scenario task drives a frame and compares the log to hand-derived values.
`timescale 1ns/1ps
module tb_qam16_frame_ctrl;

  localparam int SYM_DIV = 4;
  localparam int PRE     = 8;
  localparam int PAY     = 64;
  localparam int GRD     = 4;
  localparam int NSYM    = PRE + PAY + GRD;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] sym_code;
  logic [1:0] sym_i;
  logic [1:0] sym_q;
  logic       sym_stb;
  logic       mod_en;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [3:0] code;
    logic [1:0] i;
    logic [1:0] q;
    logic       mod_en;
    logic       done;
    logic       underrun;
  } stb_rec_t;

  stb_rec_t stb_q[$];
  int       ready_q[$];
  int       done_q[$];
  stb_rec_t mon_rec;

  qam16_frame_ctrl #(
    .SYM_DIV      (SYM_DIV),
    .PREAMBLE_LEN (PRE),
    .PAYLOAD_LEN  (PAY),
    .GUARD_LEN    (GRD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .sym_code   (sym_code),
    .sym_i      (sym_i),
    .sym_q      (sym_q),
    .sym_stb    (sym_stb),
    .mod_en     (mod_en),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Cycle index: during cycle n (between edges n and n+1) cyc reads n.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sym_stb === 1'b1) begin
      mon_rec.cyc      = cyc;
      mon_rec.code     = sym_code;
      mon_rec.i        = sym_i;
      mon_rec.q        = sym_q;
      mon_rec.mod_en   = mod_en;
      mon_rec.done     = frame_done;
      mon_rec.underrun = underrun;
      stb_q.push_back(mon_rec);
    end
    if (frame_done === 1'b1) done_q.push_back(cyc);
    if (s_ready === 1'b1) ready_q.push_back(cyc);
  end

`ifdef QAM16_SCRAMBLE_EN
  // Whitening mask for payload symbol p, rebuilt from the seed each call.
  function automatic logic [3:0] model_mask(input int p);
    logic [6:0] s;
    logic [3:0] m;
    logic       b;
    s = 7'h7F;
    m = 4'h0;
    for (int t = 0; t <= p; t++) begin
      for (int bit_pos = 3; bit_pos >= 0; bit_pos--) begin
        b = s[6] ^ s[5];
        s = {s[5:0], b};
        m[bit_pos] = b;
      end
    end
    return m;
  endfunction
`endif

  // Expected code of strobe k when the source offered raw on that tick.
  function automatic logic [3:0] exp_code(input int k, input logic [3:0] raw);
    if (k < PRE) return (k % 2 == 0) ? 4'hA : 4'h5;
    if (k < PRE + PAY) begin
`ifdef QAM16_SCRAMBLE_EN
      return raw ^ model_mask(k - PRE);
`else
      return raw;
`endif
    end
    return 4'h0;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    stb_q.delete();
    ready_q.delete();
    done_q.delete();
  endtask

  // Pulses start and feeds one frame. mode 0: steady data plus start pulses
  // while busy; mode 1: s_valid low on payload ticks 5 and 6; mode 2: tick
  // cycles carry data, off-tick cycles toggle s_valid with inverted data.
  // abort_tick >= 0 asserts reset in that tick cycle and returns at once.
  task automatic drive_frame(input int mode, input logic [3:0] data,
                             input int abort_tick, output int c0);
    start = 1'b1;
    c0 = cyc;
    step(1);
    start = 1'b0;
    for (int j = 0; j < NSYM * SYM_DIV; j++) begin
      int k;
      bit tick;
      k = j / SYM_DIV;
      tick = (j % SYM_DIV == 0);
      if (tick && k == abort_tick) begin
        reset = 1'b1;
        return;
      end
      start   = (mode == 0 && (j == 37 || j == 150));
      s_valid = 1'b1;
      s_data  = data;
      if (mode == 1 && tick && (k == PRE + 5 || k == PRE + 6)) s_valid = 1'b0;
      if (mode == 2 && !tick) begin
        s_valid = (j % 2 == 1);
        s_data  = ~data;
      end
      step(1);
    end
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 4'h0;
    step(SYM_DIV);
  endtask

  task automatic test_reset();
    clear_logs();
    step(3);
    n_checks++; if (sym_code !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_sym_code: got %h expected 0", sym_code); end
    n_checks++; if ({sym_i, sym_q} !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_iq: got %b expected 0000", {sym_i, sym_q}); end
    n_checks++; if ({sym_stb, mod_en, busy, frame_done, underrun} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00000", {sym_stb, mod_en, busy, frame_done, underrun}); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
    reset = 1'b0;
    step(5);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    n_checks++; if (stb_q.size() !== 0) begin n_fail++; $display("[TB] FAIL idle_strobes: got %0d expected 0", stb_q.size()); end
  endtask

  task automatic test_basic();
    int c0;
    clear_logs();
    drive_frame(0, 4'h3, -1, c0);
    n_checks++; if (stb_q.size() !== NSYM) begin n_fail++; $display("[TB] FAIL basic_strobe_count: got %0d expected %0d", stb_q.size(), NSYM); end
    if (stb_q.size() > 0) begin
      n_checks++; if (stb_q[0].cyc !== c0 + 2) begin n_fail++; $display("[TB] FAIL basic_first_latency: got %0d expected %0d", stb_q[0].cyc - c0, 2); end
    end
    for (int k = 0; k < stb_q.size() && k < NSYM; k++) begin
      logic [3:0] e;
      e = exp_code(k, 4'h3);
      n_checks++; if (stb_q[k].code !== e) begin n_fail++; $display("[TB] FAIL basic_code[%0d]: got %h expected %h", k, stb_q[k].code, e); end
      n_checks++; if ({stb_q[k].i, stb_q[k].q} !== {e[3], e[1], e[2], e[0]}) begin n_fail++; $display("[TB] FAIL basic_iq[%0d]: got %b expected %b", k, {stb_q[k].i, stb_q[k].q}, {e[3], e[1], e[2], e[0]}); end
      n_checks++; if (stb_q[k].mod_en !== (k < PRE + PAY)) begin n_fail++; $display("[TB] FAIL basic_mod_en[%0d]: got %b expected %b", k, stb_q[k].mod_en, (k < PRE + PAY)); end
      n_checks++; if (stb_q[k].done !== (k == NSYM - 1)) begin n_fail++; $display("[TB] FAIL basic_done[%0d]: got %b expected %b", k, stb_q[k].done, (k == NSYM - 1)); end
      if (k > 0) begin
        n_checks++; if (stb_q[k].cyc - stb_q[k-1].cyc !== SYM_DIV) begin n_fail++; $display("[TB] FAIL basic_spacing[%0d]: got %0d expected %0d", k, stb_q[k].cyc - stb_q[k-1].cyc, SYM_DIV); end
      end
    end
    n_checks++; if (done_q.size() !== 1) begin n_fail++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_q.size()); end
    n_checks++; if (ready_q.size() !== PAY) begin n_fail++; $display("[TB] FAIL basic_ready_count: got %0d expected %0d", ready_q.size(), PAY); end
    for (int p = 0; p < ready_q.size() && PRE + p < stb_q.size(); p++) begin
      n_checks++; if (ready_q[p] !== stb_q[PRE + p].cyc - 1) begin n_fail++; $display("[TB] FAIL basic_ready_align[%0d]: got cycle %0d expected %0d", p, ready_q[p], stb_q[PRE + p].cyc - 1); end
    end
    n_checks++; if ({busy, underrun} !== 2'b00) begin n_fail++; $display("[TB] FAIL basic_end_flags: got %b expected 00", {busy, underrun}); end
  endtask

  task automatic test_underrun();
    int c0;
    clear_logs();
    drive_frame(1, 4'h6, -1, c0);
    n_checks++; if (stb_q.size() !== NSYM) begin n_fail++; $display("[TB] FAIL under_strobe_count: got %0d expected %0d", stb_q.size(), NSYM); end
    n_checks++; if (ready_q.size() !== PAY) begin n_fail++; $display("[TB] FAIL under_ready_count: got %0d expected %0d", ready_q.size(), PAY); end
    for (int k = 0; k < stb_q.size() && k < NSYM; k++) begin
      logic [3:0] e;
      e = exp_code(k, (k == PRE + 5 || k == PRE + 6) ? 4'h0 : 4'h6);
      n_checks++; if (stb_q[k].code !== e) begin n_fail++; $display("[TB] FAIL under_code[%0d]: got %h expected %h", k, stb_q[k].code, e); end
      n_checks++; if (stb_q[k].underrun !== (k >= PRE + 5)) begin n_fail++; $display("[TB] FAIL under_flag[%0d]: got %b expected %b", k, stb_q[k].underrun, (k >= PRE + 5)); end
    end
    if (stb_q.size() == NSYM) begin
      n_checks++; if (stb_q[NSYM-1].done !== 1'b1) begin n_fail++; $display("[TB] FAIL under_done_last: got %b expected 1", stb_q[NSYM-1].done); end
    end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("[TB] FAIL under_sticky: got %b expected 1", underrun); end
    // A new start must clear the sticky flag on the accepting edge.
    clear_logs();
    s_valid = 1'b1;
    s_data  = 4'h6;
    start   = 1'b1;
    step(1);
    start   = 1'b0;
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL under_clear_on_start: got %b expected 0", underrun); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL under_restart_busy: got %b expected 1", busy); end
    step(NSYM * SYM_DIV + SYM_DIV);
    s_valid = 1'b0;
    n_checks++; if (stb_q.size() !== NSYM) begin n_fail++; $display("[TB] FAIL under_restart_count: got %0d expected %0d", stb_q.size(), NSYM); end
    n_checks++; if (done_q.size() !== 1) begin n_fail++; $display("[TB] FAIL under_restart_done: got %0d expected 1", done_q.size()); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL under_restart_flag: got %b expected 0", underrun); end
  endtask

  task automatic test_offtick();
    int c0;
    clear_logs();
    drive_frame(2, 4'hC, -1, c0);
    n_checks++; if (ready_q.size() !== PAY) begin n_fail++; $display("[TB] FAIL offtick_ready_count: got %0d expected %0d", ready_q.size(), PAY); end
    for (int p = 0; p < ready_q.size() && p < PAY; p++) begin
      n_checks++; if (ready_q[p] !== c0 + 1 + (PRE + p) * SYM_DIV) begin n_fail++; $display("[TB] FAIL offtick_ready_cycle[%0d]: got %0d expected %0d", p, ready_q[p], c0 + 1 + (PRE + p) * SYM_DIV); end
    end
    for (int k = PRE; k < stb_q.size() && k < PRE + PAY; k++) begin
      n_checks++; if (stb_q[k].code !== exp_code(k, 4'hC)) begin n_fail++; $display("[TB] FAIL offtick_code[%0d]: got %h expected %h", k, stb_q[k].code, exp_code(k, 4'hC)); end
    end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL offtick_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_back_to_back();
    int c0;
    clear_logs();
    s_valid = 1'b1;
    s_data  = 4'hE;
    start   = 1'b1;
    c0 = cyc;
    step(400);
    start = 1'b0;
    step(250);
    s_valid = 1'b0;
    n_checks++; if (stb_q.size() !== 2 * NSYM) begin n_fail++; $display("[TB] FAIL b2b_strobe_count: got %0d expected %0d", stb_q.size(), 2 * NSYM); end
    n_checks++; if (done_q.size() !== 2) begin n_fail++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_q.size()); end
    if (done_q.size() > 0) begin
      n_checks++; if (done_q[0] !== c0 + 2 + (NSYM - 1) * SYM_DIV) begin n_fail++; $display("[TB] FAIL b2b_first_done: got %0d expected %0d", done_q[0], c0 + 2 + (NSYM - 1) * SYM_DIV); end
    end
    if (stb_q.size() == 2 * NSYM && done_q.size() > 0) begin
      n_checks++; if (stb_q[NSYM].cyc !== done_q[0] + 2) begin n_fail++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", stb_q[NSYM].cyc - done_q[0], 2); end
      n_checks++; if (stb_q[NSYM].code !== 4'hA) begin n_fail++; $display("[TB] FAIL b2b_second_first_code: got %h expected a", stb_q[NSYM].code); end
      n_checks++; if (stb_q[2*NSYM-1].done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_second_done: got %b expected 1", stb_q[2*NSYM-1].done); end
      n_checks++; if (stb_q[NSYM + PRE].code !== exp_code(PRE, 4'hE)) begin n_fail++; $display("[TB] FAIL b2b_second_payload: got %h expected %h", stb_q[NSYM + PRE].code, exp_code(PRE, 4'hE)); end
    end
  endtask

  task automatic test_mid_reset();
    int c0;
    clear_logs();
    drive_frame(1, 4'h9, PRE + 20, c0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_s_ready_in_reset: got %b expected 0", s_ready); end
    step(1);
    n_checks++; if ({sym_code, sym_i, sym_q} !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_code: got %h expected 00", {sym_code, sym_i, sym_q}); end
    n_checks++; if ({sym_stb, mod_en, busy, frame_done, underrun} !== 5'b0) begin n_fail++; $display("[TB] FAIL midrst_flags: got %b expected 00000", {sym_stb, mod_en, busy, frame_done, underrun}); end
    reset   = 1'b0;
    s_valid = 1'b0;
    step(10);
    n_checks++; if (done_q.size() !== 0) begin n_fail++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", done_q.size()); end
    n_checks++; if (stb_q.size() !== PRE + 20) begin n_fail++; $display("[TB] FAIL midrst_strobes: got %0d expected %0d", stb_q.size(), PRE + 20); end
    clear_logs();
    drive_frame(0, 4'h9, -1, c0);
    n_checks++; if (stb_q.size() !== NSYM) begin n_fail++; $display("[TB] FAIL midrst_new_count: got %0d expected %0d", stb_q.size(), NSYM); end
    for (int k = 0; k < stb_q.size() && k < NSYM; k++) begin
      n_checks++; if (stb_q[k].code !== exp_code(k, 4'h9)) begin n_fail++; $display("[TB] FAIL midrst_new_code[%0d]: got %h expected %h", k, stb_q[k].code, exp_code(k, 4'h9)); end
    end
    n_checks++; if (done_q.size() !== 1) begin n_fail++; $display("[TB] FAIL midrst_new_done: got %0d expected 1", done_q.size()); end
  endtask

`ifdef QAM16_SCRAMBLE_EN
  task automatic test_scramble();
    int c0;
    clear_logs();
    drive_frame(0, 4'h0, -1, c0);
    if (stb_q.size() > PRE + 1) begin
      n_checks++; if ({stb_q[0].code, stb_q[1].code} !== 8'hA5) begin n_fail++; $display("[TB] FAIL scr_preamble: got %h expected a5", {stb_q[0].code, stb_q[1].code}); end
      n_checks++; if (stb_q[PRE].code !== 4'h0) begin n_fail++; $display("[TB] FAIL scr_payload0: got %h expected 0", stb_q[PRE].code); end
      n_checks++; if (stb_q[PRE+1].code !== 4'h2) begin n_fail++; $display("[TB] FAIL scr_payload1: got %h expected 2", stb_q[PRE+1].code); end
    end else begin
      n_checks++; n_fail++;
      $display("[TB] FAIL scr_strobes: got %0d expected %0d", stb_q.size(), NSYM);
    end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 4'h0;
    test_reset();
    test_basic();
    test_underrun();
    test_offtick();
    test_back_to_back();
    test_mid_reset();
`ifdef QAM16_SCRAMBLE_EN
    test_scramble();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
